// File: rtl/router_ctrl.sv
// Write-side sequencer for the 1x3 router: header decode, FIFO write steering, strobes, per-FIFO timeout.
// Optional build macro ROUTER_CTRL_ADDR_ERR_EN adds addr_err / drop_cnt for headers addressed to port 3.
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
`ifdef ROUTER_CTRL_ADDR_ERR_EN
    output logic       addr_err,
    output logic [7:0] drop_cnt,
`endif
    output logic [2:0] fsm_state
);

    // Handshake: the source may present a new data_in byte on any edge where busy is low;
    // while busy is high it must hold data_in and pkt_valid unchanged.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    logic [1:0] dest;
    logic       dropping;
    logic [1:0] addr;
    logic       addr_ok;
    logic       fullsel;
    logic       emptysel;
    logic       emptysel_da;
    logic       abort;
    logic [2:0] stall;
    logic [2:0] dest_mask;
    logic [CNT_W-1:0] cnt [3];
    logic       unused_len;

    function automatic logic sel3(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    sel3 = v[0];
            2'd1:    sel3 = v[1];
            2'd2:    sel3 = v[2];
            default: sel3 = 1'b0;
        endcase
    endfunction

    assign addr        = data_in[1:0];
    assign addr_ok     = (addr != 2'd3);
    assign unused_len  = ^data_in[7:2];
    assign fullsel     = sel3(fifo_full, dest);
    assign emptysel    = sel3(fifo_empty, dest);
    assign emptysel_da = sel3(fifo_empty, addr);
    assign abort       = sel3(soft_reset, dest);
    assign vld_out     = ~fifo_empty;
    assign stall       = vld_out & ~read_enb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            dest     <= 2'd0;
            dropping <= 1'b0;
        end else begin
            // Bytes of a header addressed to port 3 are swallowed until pkt_valid drops.
            if (!pkt_valid)
                dropping <= 1'b0;
            else if (state == DECODE_ADDRESS && !addr_ok)
                dropping <= 1'b1;

            if (state == DECODE_ADDRESS && pkt_valid && addr_ok)
                dest <= addr;

            if (state != DECODE_ADDRESS && abort) begin
                state <= DECODE_ADDRESS;
            end else begin
                case (state)
                    DECODE_ADDRESS:
                        if (pkt_valid && addr_ok && !dropping)
                            state <= emptysel_da ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    WAIT_TILL_EMPTY:
                        if (emptysel) state <= LOAD_FIRST_DATA;
                    LOAD_FIRST_DATA:
                        state <= LOAD_DATA;
                    LOAD_DATA:
                        if (fullsel)         state <= FIFO_FULL_STATE;
                        else if (!pkt_valid) state <= LOAD_PARITY;
                    FIFO_FULL_STATE:
                        if (!fullsel) state <= LOAD_AFTER_FULL;
                    LOAD_AFTER_FULL:
                        if (parity_done)        state <= DECODE_ADDRESS;
                        else if (low_pkt_valid) state <= LOAD_PARITY;
                        else                    state <= LOAD_DATA;
                    LOAD_PARITY:
                        state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR:
                        state <= fullsel ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    default:
                        state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    always_comb begin
        dest_mask = 3'b000;
        case (dest)
            2'd0:    dest_mask = 3'b001;
            2'd1:    dest_mask = 3'b010;
            2'd2:    dest_mask = 3'b100;
            default: dest_mask = 3'b000;
        endcase
    end

    always_comb begin
        write_enb   = 3'b000;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        busy        = 1'b1;
        case (state)
            DECODE_ADDRESS:     begin detect_add = 1'b1; busy = 1'b0; end
            WAIT_TILL_EMPTY:    ;
            LOAD_FIRST_DATA:    begin lfd_state = 1'b1; write_enb = dest_mask; end
            LOAD_DATA:          begin ld_state = 1'b1; busy = 1'b0; write_enb = dest_mask; end
            FIFO_FULL_STATE:    full_state = 1'b1;
            LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb = dest_mask; end
            LOAD_PARITY:        write_enb = dest_mask;
            CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
            default:            ;
        endcase
    end

    assign fsm_state = state;

    // Pulse lands on the edge after the TIMEOUT-th consecutive stalled cycle; counter rests during the pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            soft_reset <= 3'b000;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (soft_reset[i]) begin
                    soft_reset[i] <= 1'b0;
                    cnt[i]        <= '0;
                end else if (stall[i]) begin
                    if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
                        soft_reset[i] <= 1'b1;
                        cnt[i]        <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

`ifdef ROUTER_CTRL_ADDR_ERR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            addr_err <= 1'b0;
            if (state == DECODE_ADDRESS && pkt_valid && !addr_ok && !dropping) begin
                addr_err <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet flows, wait/full paths, timeout, abort, async reset, port-3 drop.
module tb_router_ctrl;

    localparam logic [2:0] S_DA  = 3'd0, S_WTE = 3'd1, S_LFD = 3'd2, S_LD  = 3'd3,
                           S_FFS = 3'd4, S_LAF = 3'd5, S_LP  = 3'd6, S_CPE = 3'd7;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic       parity_done, low_pkt_valid;
    logic [2:0] write_enb, vld_out, soft_reset, fsm_state;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
`ifdef ROUTER_CTRL_ADDR_ERR_EN
    logic       addr_err;
    logic [7:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int rst_seen = 0;
    int we_seen  = 0;
    logic [2:0] exp_q[$];

    router_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb(write_enb), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .vld_out(vld_out),
        .soft_reset(soft_reset),
`ifdef ROUTER_CTRL_ADDR_ERR_EN
        .addr_err(addr_err), .drop_cnt(drop_cnt),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] exp_strobes(input logic [2:0] st);
        case (st)
            S_DA:    exp_strobes = 6'b100000;
            S_LFD:   exp_strobes = 6'b010000;
            S_LD:    exp_strobes = 6'b001000;
            S_LAF:   exp_strobes = 6'b000100;
            S_FFS:   exp_strobes = 6'b000010;
            S_CPE:   exp_strobes = 6'b000001;
            default: exp_strobes = 6'b000000;
        endcase
    endfunction

    function automatic logic [2:0] exp_we(input logic [2:0] st, input logic [1:0] d);
        logic [2:0] m;
        m = 3'b001 << d;
        exp_we = (st == S_LFD || st == S_LD || st == S_LAF || st == S_LP) ? m : 3'b000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte for the current cycle, then check the state entered on the next edge.
    task automatic drive(input logic pv, input logic [7:0] d, input logic [2:0] st,
                         input logic [1:0] dst, input string tag);
        logic [2:0] e;
        pkt_valid = pv;
        data_in   = d;
        exp_q.push_back(st);
        cyc();
        e = exp_q.pop_front();
        check({tag, ".state"}, fsm_state, e);
        check({tag, ".we"}, write_enb, exp_we(e, dst));
        check({tag, ".busy"}, busy, (e == S_DA || e == S_LD) ? 1'b0 : 1'b1);
        check({tag, ".strb"}, {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg},
              exp_strobes(e));
        rst_seen += int'(rst_int_reg);
        if (write_enb != 3'b000) we_seen++;
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
        fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", fsm_state, S_DA);
        check("rst.outs", {write_enb, busy, detect_add, soft_reset, vld_out}, {3'b000, 1'b0, 1'b1, 3'b000, 3'b000});
        @(negedge clk);
        resetn = 1'b1;

        // Packet to FIFO0: header, 4 payload, parity.
        rst_seen = 0; we_seen = 0;
        drive(1, 8'h14, S_LFD, 0, "p0.hdr");
        drive(1, 8'h14, S_LD,  0, "p0.lfd");
        for (int i = 0; i < 4; i++) drive(1, 8'hA0 + 8'(i), S_LD, 0, "p0.pay");
        drive(0, 8'h5A, S_LP,  0, "p0.par");
        drive(0, 8'h00, S_CPE, 0, "p0.lp");
        drive(0, 8'h00, S_DA,  0, "p0.cpe");
        check("p0.we_cycles", we_seen, 7);
        check("p0.rst_pulses", rst_seen, 1);

        // Destination 1 busy: wait, then release.
        fifo_empty = 3'b101;
        drive(1, 8'h05, S_WTE, 1, "p1.hdr");
        drive(1, 8'h05, S_WTE, 1, "p1.wait");
        fifo_empty = 3'b111;
        drive(1, 8'h05, S_LFD, 1, "p1.rel");
        drive(0, 8'h77, S_LD,  1, "p1.lfd");
        drive(0, 8'h77, S_LP,  1, "p1.par");
        drive(0, 8'h00, S_CPE, 1, "p1.lp");
        drive(0, 8'h00, S_DA,  1, "p1.cpe");

        // Destination 2 with FIFO full during load, then full again at parity check.
        drive(1, 8'h0A, S_LFD, 2, "p2.hdr");
        drive(1, 8'h0A, S_LD,  2, "p2.lfd");
        fifo_full = 3'b100;
        for (int i = 0; i < 4; i++) drive(1, 8'hB0, S_FFS, 2, "p2.full");
        fifo_full = 3'b000;
        drive(1, 8'hB0, S_LAF, 2, "p2.rel");
        drive(1, 8'hB0, S_LD,  2, "p2.laf");
        drive(0, 8'hC3, S_LP,  2, "p2.par");
        drive(0, 8'h00, S_CPE, 2, "p2.lp");
        fifo_full = 3'b100;
        drive(0, 8'h00, S_FFS, 2, "p2.cpefull");
        fifo_full = 3'b000;
        drive(0, 8'h00, S_LAF, 2, "p2.rel2");
        parity_done = 1'b1;
        drive(0, 8'h00, S_DA,  2, "p2.pdone");
        parity_done = 1'b0;

        // Timeout on FIFO0: pulse after the 30th stalled cycle only.
        fifo_empty = 3'b110;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            check($sformatf("to.k%0d", k), soft_reset, (k == 30) ? 3'b001 : 3'b000);
        end
        check("to.vld", vld_out, 3'b001);
        cyc();
        check("to.one_cycle", soft_reset, 3'b000);
        fifo_empty = 3'b111;
        cyc();
        fifo_empty = 3'b110;
        repeat (28) cyc();
        read_enb = 3'b001;
        cyc();
        check("to.read29", soft_reset, 3'b000);
        read_enb = 3'b000;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            check($sformatf("to.rk%0d", k), soft_reset, (k == 30) ? 3'b001 : 3'b000);
        end
        fifo_empty = 3'b111;
        repeat (2) cyc();

        // Soft reset of the active destination aborts a load, overriding LD -> LP.
        drive(1, 8'h04, S_LFD, 0, "ab.hdr");
        drive(1, 8'h04, S_LD,  0, "ab.lfd");
        fifo_empty = 3'b110;
        for (int k = 1; k <= 30; k++) drive(1, 8'h22, S_LD, 0, "ab.ld");
        check("ab.soft", soft_reset, 3'b001);
        drive(0, 8'h22, S_DA, 0, "ab.abort");
        fifo_empty = 3'b111;
        cyc();

        // Async reset mid-load.
        drive(1, 8'h05, S_LFD, 1, "ar.hdr");
        drive(1, 8'h05, S_LD,  1, "ar.lfd");
        #2 resetn = 1'b0;
        #1;
        check("ar.state", fsm_state, S_DA);
        check("ar.outs", {write_enb, busy, detect_add, lfd_state, ld_state, soft_reset},
              {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000});
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 8'h00, S_DA, 1, "ar.after");

        // Header addressed to port 3 is dropped with its payload bytes.
        drive(1, 8'h0F, S_DA, 0, "drop.hdr");
`ifdef ROUTER_CTRL_ADDR_ERR_EN
        check("drop.err1", addr_err, 1'b1);
`endif
        for (int i = 0; i < 3; i++) drive(1, 8'h01, S_DA, 0, "drop.pay");
`ifdef ROUTER_CTRL_ADDR_ERR_EN
        check("drop.err0", addr_err, 1'b0);
        check("drop.cnt1", drop_cnt, 8'd1);
`endif
        drive(0, 8'h00, S_DA, 0, "drop.end");
`ifdef ROUTER_CTRL_ADDR_ERR_EN
        for (int i = 0; i < 300; i++) begin
            pkt_valid = 1'b1; data_in = 8'h0F; cyc();
            pkt_valid = 1'b0; cyc();
        end
        check("drop.sat", drop_cnt, 8'd255);
        check("drop.state", fsm_state, S_DA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
